// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves IF fetches and MEM loads/stores
// (MEM first) over an 8-bit synchronous RAM, one byte per cycle.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  input  logic              me_req_i,
  input  logic              me_we_i,
  input  logic [1:0]        me_len_i,
  input  logic              me_sext_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  input  logic [31:0]       me_wdata_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              ram_busy_o,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  output logic [31:0]       me_rdata_o,
  output logic              me_done_o
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IF_RD = 3'd1,
    S_ME_RD = 3'd2,
    S_ME_WR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    nbytes_q, nbytes_d;
  logic [1:0]          len_q, len_d;
  logic                sext_q, sext_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [ADDR_W-1:0]   mem_a_d;
  logic [7:0]          mem_dout_d;
  logic                mem_wr_d;
  logic                ram_busy_d;
  logic [DATA_W-1:0]   if_inst_d, me_rdata_d;
  logic                if_done_d, me_done_d;
  logic [1:0]          byte_idx_c;

  // Byte slot filled by the RAM data returning this cycle (address issued last cycle).
  assign byte_idx_c = 2'(cnt_q - 3'd2);

  // Zero- or sign-extend a byte/half load; word loads pass through.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] len,
                                                    input logic sext);
    logic [DATA_W-1:0] r;
    case (len)
      2'b00:   r = sext ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
      2'b01:   r = sext ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      len_q      <= '0;
      sext_q     <= 1'b0;
      wdata_q    <= '0;
      base_q     <= '0;
      rbuf_q     <= '0;
      mem_a_o    <= '0;
      mem_dout_o <= '0;
      mem_wr_o   <= 1'b0;
      ram_busy_o <= 1'b0;
      if_inst_o  <= '0;
      if_done_o  <= 1'b0;
      me_rdata_o <= '0;
      me_done_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      len_q      <= len_d;
      sext_q     <= sext_d;
      wdata_q    <= wdata_d;
      base_q     <= base_d;
      rbuf_q     <= rbuf_d;
      mem_a_o    <= mem_a_d;
      mem_dout_o <= mem_dout_d;
      mem_wr_o   <= mem_wr_d;
      ram_busy_o <= ram_busy_d;
      if_inst_o  <= if_inst_d;
      if_done_o  <= if_done_d;
      me_rdata_o <= me_rdata_d;
      me_done_o  <= me_done_d;
    end
  end

  // Next-state and next-output logic; cnt_q is the cycle number within a transfer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    len_d      = len_q;
    sext_d     = sext_q;
    wdata_d    = wdata_q;
    base_d     = base_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_o;
    mem_dout_d = 8'd0;
    mem_wr_d   = 1'b0;
    if_inst_d  = if_inst_o;
    me_rdata_d = me_rdata_o;
    if_done_d  = 1'b0;
    me_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_a_d = '0;
        if (me_req_i) begin
          base_d  = me_addr_i;
          len_d   = me_len_i;
          sext_d  = me_sext_i;
          wdata_d = me_wdata_i;
          case (me_len_i)
            2'b00:   nbytes_d = 3'd1;
            2'b01:   nbytes_d = 3'd2;
            default: nbytes_d = 3'd4;
          endcase
          cnt_d   = 3'd1;
          rbuf_d  = '0;
          mem_a_d = me_addr_i;
          if (me_we_i) begin
            state_d    = S_ME_WR;
            mem_dout_d = me_wdata_i[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = S_ME_RD;
          end
        end else if (if_req_i && !flush_i) begin
          base_d   = if_addr_i;
          len_d    = 2'b10;
          sext_d   = 1'b0;
          nbytes_d = 3'd4;
          cnt_d    = 3'd1;
          rbuf_d   = '0;
          mem_a_d  = if_addr_i;
          state_d  = S_IF_RD;
        end
      end

      S_IF_RD, S_ME_RD: begin
        if (state_q == S_IF_RD && flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          if (cnt_q >= 3'd2) begin
            rbuf_d[{byte_idx_c, 3'b000} +: 8] = mem_din_i;
          end
          if (cnt_q < nbytes_q) begin
            mem_a_d = base_q + ADDR_W'(cnt_q);
          end
          if (cnt_q == nbytes_q + 3'd1) begin
            state_d = S_DONE;
            cnt_d   = '0;
            mem_a_d = '0;
            if (state_q == S_IF_RD) begin
              if_inst_d = rbuf_d;
              if_done_d = 1'b1;
            end else begin
              me_rdata_d = extend_load(rbuf_d, len_q, sext_q);
              me_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_ME_WR: begin
        if (cnt_q < nbytes_q) begin
          mem_a_d    = base_q + ADDR_W'(cnt_q);
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d   = S_DONE;
          cnt_d     = '0;
          mem_a_d   = '0;
          me_done_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        mem_a_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        mem_a_d = '0;
      end
    endcase

    ram_busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed table, hand sequences for
// multi-cycle corners, and random traffic against a transaction-level model.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        me_req;
  logic        me_we;
  logic [1:0]  me_len;
  logic        me_sext;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        ram_busy;
  logic [31:0] if_inst;
  logic        if_done;
  logic [31:0] me_rdata;
  logic        me_done;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .flush_i(flush),
    .me_req_i(me_req), .me_we_i(me_we), .me_len_i(me_len), .me_sext_i(me_sext),
    .me_addr_i(me_addr), .me_wdata_i(me_wdata),
    .mem_din_i(mem_din), .mem_a_o(mem_a), .mem_dout_o(mem_dout), .mem_wr_o(mem_wr),
    .ram_busy_o(ram_busy), .if_inst_o(if_inst), .if_done_o(if_done),
    .me_rdata_o(me_rdata), .me_done_o(me_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM seen by the DUT, plus the model's own shadow copy.
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  // RAM: data for an address appears one cycle later.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_if_inst  = 32'd0;
  logic [31:0] exp_me_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (ram_busy !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    if (ram_busy !== 1'b0) chk("wait_idle_timeout", {31'd0, ram_busy}, 32'd0);
  endtask

  // Model: bytes per access and result of a load, from the shadow memory.
  function automatic int nbytes(input logic is_if, input logic [1:0] len);
    if (is_if) return 4;
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n,
                                             input logic sext);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(sh_rd(a + 32'(i))) << (8 * i));
    if (n == 1) v = (sext && v[7])  ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
    if (n == 2) v = (sext && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input int n,
                                      input logic [31:0] d);
    for (int i = 0; i < n; i++) shadow[a + 32'(i)] = 8'((d >> (8 * i)) & 32'hFF);
  endfunction

  // One complete transaction from IDLE; checks latency, data, and result holding.
  task automatic do_txn(input string name, input logic is_if, input logic we,
                        input logic [1:0] len, input logic sext, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_lat);
    int lat;
    wait_idle();
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      me_req = 1'b1; me_we = we; me_len = len; me_sext = sext;
      me_addr = addr; me_wdata = wdata;
    end
    tick();
    if_req = 1'b0;
    me_req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if ((is_if && me_done) || (!is_if && if_done)) begin
        chk({name, "_wrong_done"}, 32'd1, 32'd0);
      end
      if ((is_if && if_done) || (!is_if && me_done)) begin
        lat = c;
        break;
      end
      tick();
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      if (is_if) exp_if_inst = exp_data;
      else if (!we) exp_me_rdata = exp_data;
      chk({name, "_if_inst"}, if_inst, exp_if_inst);
      chk({name, "_me_rdata"}, me_rdata, exp_me_rdata);
      tick();
      chk({name, "_done_pulse"}, {30'd0, if_done, me_done}, 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic        is_if;
    logic        we;
    logic [1:0]  len;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int seen, if_c, me_c;
    logic [31:0] v_addr, v_wdata, v_exp;
    logic [1:0]  v_len;
    logic        v_sext, v_if, v_we;
    int          v_n;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    me_req = 1'b0; me_we = 1'b0; me_len = '0; me_sext = 1'b0;
    me_addr = '0; me_wdata = '0;

    preload(32'h4, 8'h13); preload(32'h5, 8'h05); preload(32'h6, 8'h00); preload(32'h7, 8'h00);
    preload(32'h0, 8'hCC); preload(32'h1, 8'hDD); preload(32'h2, 8'hEE); preload(32'h3, 8'h0F);
    preload(32'h10, 8'h80);
    preload(32'h40, 8'h11); preload(32'h41, 8'h22); preload(32'h42, 8'h33); preload(32'h43, 8'h84);
    preload(32'hFFFFFFFE, 8'hAA); preload(32'hFFFFFFFF, 8'hBB);

    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {mem_a | if_inst | me_rdata}, 32'd0);
    chk("reset_ctrl", {24'd0, mem_dout}, 32'd0);
    chk("reset_flags", {27'd0, mem_wr, ram_busy, if_done, me_done, 1'b0}, 32'd0);

    // Word fetch at 4: address sequence, busy window, single done pulse.
    wait_idle();
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    if_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) chk($sformatf("fetch_addr_c%0d", c), mem_a, 32'h4 + 32'(c - 1));
      if (c == 5) chk("fetch_addr_hold", mem_a, 32'h7);
      chk($sformatf("fetch_busy_c%0d", c), {31'd0, ram_busy}, (c <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("fetch_done_c%0d", c), {31'd0, if_done}, (c == 6) ? 32'd1 : 32'd0);
      if (mem_wr) chk("fetch_no_write", {31'd0, mem_wr}, 32'd0);
      if (c == 6) chk("fetch_inst", if_inst, 32'h00000513);
      tick();
    end
    exp_if_inst = 32'h00000513;

    vecs[0]  = '{"if_w4",     1, 0, 2'b10, 0, 32'h4,        32'h0,        32'h00000513, 6};
    vecs[1]  = '{"lb_sx",     0, 0, 2'b00, 1, 32'h10,       32'h0,        32'hFFFFFF80, 3};
    vecs[2]  = '{"lbu",       0, 0, 2'b00, 0, 32'h10,       32'h0,        32'h00000080, 3};
    vecs[3]  = '{"lw",        0, 0, 2'b10, 0, 32'h40,       32'h0,        32'h84332211, 6};
    vecs[4]  = '{"lh_sx",     0, 0, 2'b01, 1, 32'h42,       32'h0,        32'hFFFF8433, 4};
    vecs[5]  = '{"lhu",       0, 0, 2'b01, 0, 32'h42,       32'h0,        32'h00008433, 4};
    vecs[6]  = '{"lw_wrap",   0, 0, 2'b10, 0, 32'hFFFFFFFE, 32'h0,        32'hDDCCBBAA, 6};
    vecs[7]  = '{"len11",     0, 0, 2'b11, 1, 32'h40,       32'h0,        32'h84332211, 6};
    vecs[8]  = '{"sh",        0, 1, 2'b01, 0, 32'h21,       32'hABCD1234, 32'h0,        3};
    vecs[9]  = '{"lw_after",  0, 0, 2'b10, 0, 32'h20,       32'h0,        32'h00123400, 6};
    vecs[10] = '{"sb",        0, 1, 2'b00, 0, 32'h23,       32'h7777775A, 32'h0,        2};
    vecs[11] = '{"lw_sb",     0, 0, 2'b10, 0, 32'h20,       32'h0,        32'h5A123400, 6};
    vecs[12] = '{"sw_wrap",   0, 1, 2'b10, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h0,        5};
    vecs[13] = '{"lw_wrap2",  0, 0, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D, 6};
    vecs[14] = '{"if_w0",     1, 0, 2'b10, 0, 32'h0,        32'h0,        32'h0FCAFEF0, 6};
    vecs[15] = '{"lw_sx",     0, 0, 2'b10, 1, 32'h40,       32'h0,        32'h84332211, 6};
    vecs[16] = '{"lb_sx_hi",  0, 0, 2'b00, 1, 32'h43,       32'h0,        32'hFFFFFF84, 3};

    for (int i = 0; i < 17; i++) begin
      do_txn(vecs[i].name, vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].sext,
             vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_lat);
    end
    // Keep the model's shadow in step with the table's stores.
    model_store(32'h21, 2, 32'hABCD1234);
    model_store(32'h23, 1, 32'h7777775A);
    model_store(32'hFFFFFFFF, 4, 32'hCAFEF00D);

    // Simultaneous IF and MEM: MEM first, IF accepted once idle again.
    for (int s = 1; s >= 0; s--) begin
      wait_idle();
      if_req = 1'b1; if_addr = 32'h0;
      me_req = 1'b1; me_we = 1'b0; me_len = 2'b00; me_sext = 1'(s); me_addr = 32'h10;
      tick();
      me_req = 1'b0;
      if_c = 0; me_c = 0;
      for (int c = 1; c <= 20; c++) begin
        if (me_done) begin
          me_c = c;
          chk($sformatf("prio_me_rdata_s%0d", s), me_rdata, s ? 32'hFFFFFF80 : 32'h00000080);
        end
        if (if_done) begin
          if_c = c;
          if_req = 1'b0;
          chk($sformatf("prio_if_inst_s%0d", s), if_inst, 32'h0FCAFEF0);
          tick();
          break;
        end
        tick();
      end
      if_req = 1'b0;
      chk($sformatf("prio_me_cycle_s%0d", s), 32'(me_c), 32'd3);
      chk($sformatf("prio_if_cycle_s%0d", s), 32'(if_c), 32'd10);
    end
    exp_if_inst  = 32'h0FCAFEF0;
    exp_me_rdata = 32'h00000080;

    // Half store byte trace.
    wait_idle();
    me_req = 1'b1; me_we = 1'b1; me_len = 2'b01; me_addr = 32'h21; me_wdata = 32'hABCD1234;
    tick();
    me_req = 1'b0;
    chk("sh_c1", {mem_a[23:0], mem_dout}, {24'h000021, 8'h34});
    chk("sh_c1_wr", {31'd0, mem_wr}, 32'd1);
    tick();
    chk("sh_c2", {mem_a[23:0], mem_dout}, {24'h000022, 8'h12});
    chk("sh_c2_wr", {31'd0, mem_wr}, 32'd1);
    tick();
    chk("sh_c3", {29'd0, mem_wr, me_done, 1'b0}, {29'd0, 1'b0, 1'b1, 1'b0});
    chk("sh_c3_dout", {24'd0, mem_dout}, 32'd0);
    tick();
    chk("sh_c4_wr", {31'd0, mem_wr}, 32'd0);
    chk("sh_ram", {16'd0, ram_rd(32'h22), ram_rd(32'h21)}, 32'h00001234);

    // Flush aborts a fetch in cycle 3; then a fresh fetch completes.
    wait_idle();
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    if_req = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    chk("flush_busy_c3", {31'd0, ram_busy}, 32'd1);
    tick();
    flush = 1'b0;
    chk("flush_idle_c4", {31'd0, ram_busy}, 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (if_done || if_inst !== exp_if_inst) seen++;
      tick();
    end
    chk("flush_no_done_hold", 32'(seen), 32'd0);
    do_txn("after_flush", 1, 0, 2'b10, 0, 32'h4, 32'h0, 32'h00000513, 6);

    // Flush in IDLE blocks IF acceptance that cycle.
    wait_idle();
    if_req = 1'b1; if_addr = 32'h4; flush = 1'b1;
    tick();
    if_req = 1'b0; flush = 1'b0;
    chk("flush_idle_block", {31'd0, ram_busy}, 32'd0);

    // Random traffic against the model.
    for (int a = 0; a < 68; a++) preload(32'h1000 + 32'(a), 8'($urandom_range(0, 255)));
    for (int a = 0; a < 8; a++) preload(32'hFFFFFFF8 + 32'(a), 8'($urandom_range(0, 255)));
    for (int a = 0; a < 8; a++) preload(32'(a), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 60; i++) begin
      v_if    = ($urandom_range(0, 3) == 0);
      v_we    = v_if ? 1'b0 : 1'($urandom_range(0, 1));
      v_len   = 2'($urandom_range(0, 3));
      v_sext  = 1'($urandom_range(0, 1));
      v_addr  = (i % 6 == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 5)))
                             : (32'h1000 + 32'($urandom_range(0, 63)));
      v_wdata = $urandom;
      v_n     = nbytes(v_if, v_len);
      v_exp   = (v_if || !v_we) ? model_load(v_addr, v_n, v_if ? 1'b0 : v_sext) : 32'h0;
      do_txn($sformatf("rnd%0d", i), v_if, v_we, v_len, v_sext, v_addr, v_wdata, v_exp,
             v_we ? v_n + 1 : v_n + 2);
      if (v_we) model_store(v_addr, v_n, v_wdata);
    end

    // Reset in cycle 2 of a word store.
    wait_idle();
    me_req = 1'b1; me_we = 1'b1; me_len = 2'b10; me_addr = 32'h2000; me_wdata = 32'h01020304;
    tick();
    me_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_data", {mem_a | if_inst | me_rdata}, 32'd0);
    chk("rst_mid_flags", {23'd0, mem_dout, mem_wr}, 32'd0);
    chk("rst_mid_busy", {30'd0, ram_busy, me_done}, 32'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (me_done || mem_wr || ram_busy) seen++;
      tick();
    end
    chk("rst_no_done", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the IF and MEM stages and the 8-bit synchronous program/data RAM.
- Serves instruction fetches from IF and load/store requests from MEM, with MEM given priority.
- Assembles or splits 32-bit words one byte per cycle and returns results with a one-cycle done pulse.
- Drives the ram_busy signal that IF and MEM use to launch requests.

Parameters:
- ADDR_W, 32, byte address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- if_req_i  input  1  IF fetch request
- if_addr_i  input  32  fetch address
- flush_i  input  1  branch flush; aborts an in-flight IF read
- me_req_i  input  1  MEM access request
- me_we_i  input  1  1 = store, 0 = load
- me_len_i  input  2  00 byte, 01 half, 10 word, 11 treated as word
- me_sext_i  input  1  sign-extend byte/half loads
- me_addr_i  input  32  MEM byte address
- me_wdata_i  input  32  store data
- mem_din_i  input  8  RAM read data, valid one cycle after its address
- mem_a_o  output  32  RAM address
- mem_dout_o  output  8  RAM write data
- mem_wr_o  output  1  RAM write enable
- ram_busy_o  output  1  controller not idle
- if_inst_o  output  32  fetched instruction
- if_done_o  output  1  one-cycle fetch-complete pulse
- me_rdata_o  output  32  load result
- me_done_o  output  1  one-cycle load/store-complete pulse

Behaviour:
- Reset (rst high at an edge): state IDLE, counter 0; every output 0, including mem_wr_o, if_inst_o and me_rdata_o. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, IF_RD, ME_RD, ME_WR, DONE.
- IDLE:
  - me_req_i high → ME_WR or ME_RD.
  - else if_req_i high and flush_i low → IF_RD.
  - On acceptance, latch address, length, we, wdata and sext.
- Byte count N: IF = 4; MEM = 1, 2 or 4 from me_len_i.
- Request holding: requests need only be valid on the accepting edge. The requester deasserts req in the cycle it sees its done pulse. A req still high in IDLE is a new request.
- Simultaneous me_req_i and if_req_i in IDLE: MEM wins; IF stays pending and is accepted on a later IDLE cycle.
- Reads (cycles counted from 1 after the accepting edge):
  - Cycle k (1..N): mem_a_o = base + (k−1), mem_wr_o = 0.
  - Byte from cycle k is captured at the end of cycle k+1.
  - Byte i goes to bits [8i+7:8i] (little-endian).
  - Cycle N+1: address undefined-but-stable (hold last), last capture.
  - Cycle N+2: DONE, with the done pulse and valid data.
- Writes:
  - Cycle k (1..N): mem_a_o = base + (k−1), mem_dout_o = wdata byte k−1, mem_wr_o = 1.
  - Cycle N+1: DONE.
- Done latency:
  - word read: cycle 6; half read: cycle 4; byte read: cycle 3
  - word write: cycle 5; half write: cycle 3; byte write: cycle 2
- Done pulse: if_done_o or me_done_o is high for exactly the DONE cycle. DONE → IDLE unconditionally.
- Result holding: if_inst_o and me_rdata_o update only on their own completion and hold otherwise.
- Load extension: byte/half loads are zero-extended, or sign-extended from bit 7/15 when me_sext_i = 1. Word loads are unaffected.
- Store data: mem_dout_o = 0 and mem_wr_o = 0 whenever not in ME_WR.
- IDLE outputs: mem_a_o = 0.
- ram_busy_o = (state != IDLE). It is registered, so it is high from cycle 1 through the DONE cycle.
- Alignment and wrap: misaligned addresses are legal. Address increments wrap 0xFFFFFFFF → 0x00000000.
- flush_i:
  - In IF_RD: next state IDLE, no if_done_o, if_inst_o unchanged.
  - Ignored in ME_RD, ME_WR (stores never aborted) and DONE.
  - In IDLE: blocks IF acceptance that cycle.

Test Plan:
- IF fetch at 0x00000004, RAM[4..7] = 13 05 00 00 → mem_a_o 4, 5, 6, 7 in cycles 1–4; if_done_o in cycle 6 only; if_inst_o = 0x00000513; ram_busy_o high in cycles 1–6.
- if_req_i (addr 0x0) and me_req_i (signed byte load, 0x10, RAM = 0x80) in the same cycle → me_done_o in cycle 3 with me_rdata_o = 0xFFFFFF80; IF accepted next IDLE cycle (cycle 4), if_done_o in cycle 10. Repeat with me_sext_i = 0 → 0x00000080.
- Half store 0xABCD1234 to 0x21 → writes 0x34@0x21 (cycle 1), 0x12@0x22 (cycle 2); me_done_o in cycle 3; mem_wr_o low otherwise; 0xAB/0xCD never written.
- IF fetch with flush_i high in cycle 3 → IDLE in cycle 4, no if_done_o, if_inst_o holds old value; new IF request then completes normally.
- Word load at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; data assembled little-endian.
- rst asserted in cycle 2 of a word store → mem_wr_o = 0 and all outputs 0 from the next cycle; no me_done_o; ram_busy_o = 0.
